// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core pipeline front end.
//   RESET_PC_DEFAULT : byte address fetched first after reset
//   OP_JUMP          : low three instruction bits that mark an absolute jump
//   NOP_INST         : word presented to decode when nothing is valid
//   fetch_state_t    : fetch-stage state encoding
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [26:0] RESET_PC_DEFAULT = 27'h0;
    localparam logic [2:0]  OP_JUMP          = 3'b111;
    localparam logic [31:0] NOP_INST         = 32'h0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,   // nothing presented yet
        RUN  = 2'd1,   // presented word comes straight from imem_rdata
        HOLD = 2'd2    // presented word was captured while decode stalled
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction-fetch stage. Issues word-address read requests to an external
// instruction memory with one cycle of read latency and presents each returned
// word to decode together with its byte PC. Handles pipeline stalls without
// losing or duplicating instructions, absolute jumps decoded in fetch, and
// branch redirects from execute.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   n_stall     : global pipeline enable (0 = hold)
//   dec_nstall  : decode ready (0 = decode cannot accept)
//   flush       : taken-branch redirect from execute
//   br_target   : byte address of the branch target (valid with flush)
//   imem_en     : instruction-memory read request
//   imem_addr   : word address of the request
//   imem_rdata  : instruction word, valid the cycle after imem_en
//   inst        : instruction presented to decode
//   if_pc       : byte PC of inst
// -----------------------------------------------------------------------------
module fetch
    import core_pkg::*;
#(
    parameter logic [26:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        n_stall,
    input  logic        dec_nstall,
    input  logic        flush,
    input  logic [26:0] br_target,
    output logic        imem_en,
    output logic [24:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [26:0] if_pc
);

    fetch_state_t state_reg, state_next;
    logic [26:0]  pc_reg, pc_next;
    logic [31:0]  hold_inst_reg, hold_inst_next;
    logic [26:0]  hold_pc_reg, hold_pc_next;

    logic        advance;
    logic        req;
    logic [26:0] pc_seq;
    logic [26:0] jump_target;

    assign advance     = n_stall & dec_nstall;
    // Wraps modulo 2^27 by width truncation.
    assign pc_seq      = pc_reg + 27'd4;
    assign jump_target = {inst[30:6], 2'b00};

    // Word presented to decode and its PC.
    always_comb begin
        inst  = NOP_INST;
        if_pc = 27'h0;
        case (state_reg)
            RUN: begin
                inst  = imem_rdata;
                if_pc = pc_reg;
            end
            HOLD: begin
                inst  = hold_inst_reg;
                if_pc = hold_pc_reg;
            end
            default: begin
                inst  = NOP_INST;
                if_pc = 27'h0;
            end
        endcase
    end

    // Next-state and request generation. pc_next doubles as the byte address
    // of the request whenever req is set.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        hold_inst_next = hold_inst_reg;
        hold_pc_next   = hold_pc_reg;
        req            = 1'b0;

        if (flush) begin
            req            = 1'b1;
            pc_next        = br_target;
            state_next     = RUN;
            hold_inst_next = NOP_INST;
            hold_pc_next   = 27'h0;
        end else begin
            case (state_reg)
                BOOT: begin
                    // Leave BOOT unconditionally; stalls cannot apply before
                    // anything has been presented.
                    req        = 1'b1;
                    pc_next    = RESET_PC;
                    state_next = RUN;
                end
                RUN, HOLD: begin
                    if (advance) begin
                        req        = 1'b1;
                        state_next = RUN;
                        if (inst[2:0] == OP_JUMP) begin
                            pc_next = jump_target;
                        end else begin
                            pc_next = pc_seq;
                        end
                    end else if (state_reg == RUN) begin
                        // imem_rdata is only valid this cycle; capture it.
                        hold_inst_next = imem_rdata;
                        hold_pc_next   = pc_reg;
                        state_next     = HOLD;
                    end
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    // No request leaves the stage while reset is asserted.
    assign imem_en   = req & ~rst;
    assign imem_addr = imem_en ? pc_next[26:2] : pc_reg[26:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            hold_inst_reg <= NOP_INST;
            hold_pc_reg   <= 27'h0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            hold_inst_reg <= hold_inst_next;
            hold_pc_reg   <= hold_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
// Directed, table-driven bench for the fetch stage. A behavioural instruction
// memory returns word[i] = i (with bit 0 cleared whenever the low three bits
// would be 111, so no accidental jumps), optionally with a jump word at word 2.
// Each row gives the inputs for one cycle and the outputs expected in it.
// -----------------------------------------------------------------------------
module tb_fetch;

    logic        clk;
    logic        rst;
    logic        n_stall;
    logic        dec_nstall;
    logic        flush;
    logic [26:0] br_target;
    logic        imem_en;
    logic [24:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [26:0] if_pc;

    int checks = 0;
    int errors = 0;
    logic jump_en = 1'b0;

    fetch dut (
        .clk        (clk),
        .rst        (rst),
        .n_stall    (n_stall),
        .dec_nstall (dec_nstall),
        .flush      (flush),
        .br_target  (br_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .if_pc      (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [24:0] a);
        logic [31:0] w;
        if (jump_en && a == 25'd2) return 32'h0000_1007; // jump, inst[30:6]=0x40
        w = {7'b0, a};
        if (a[2:0] == 3'b111) w[0] = 1'b0;
        return w;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    typedef struct {
        logic        r, ns, dn, fl;
        logic [26:0] bt;
        logic [31:0] ei;
        logic [26:0] ep;
        logic        ee;
        logic [24:0] ea;
    } vec_t;

    function automatic vec_t mk(input logic r, ns, dn, fl, input logic [26:0] bt,
                                input logic [31:0] ei, input logic [26:0] ep,
                                input logic ee, input logic [24:0] ea);
        vec_t v;
        v.r = r; v.ns = ns; v.dn = dn; v.fl = fl; v.bt = bt;
        v.ei = ei; v.ep = ep; v.ee = ee; v.ea = ea;
        return v;
    endfunction

    task automatic cmp(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle; optionally check outputs mid-cycle, then advance.
    task automatic apply(input string tag, input int row, input vec_t v, input bit chk);
        rst = v.r; n_stall = v.ns; dec_nstall = v.dn; flush = v.fl; br_target = v.bt;
        #2;
        if (chk) begin
            cmp({tag, ".inst"},      row, inst, v.ei);
            cmp({tag, ".if_pc"},     row, {5'b0, if_pc}, {5'b0, v.ep});
            cmp({tag, ".imem_en"},   row, {31'b0, imem_en}, {31'b0, v.ee});
            cmp({tag, ".imem_addr"}, row, {7'b0, imem_addr}, {7'b0, v.ea});
            $display("%s row %0d: rst=%b ns=%b dn=%b fl=%b -> inst=%h pc=%h en=%b addr=%h",
                     tag, row, v.r, v.ns, v.dn, v.fl, inst, if_pc, imem_en, imem_addr);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t main_tab[24];
    vec_t jmp_tab[13];

    initial begin
        rst = 1'b1; n_stall = 1'b1; dec_nstall = 1'b1; flush = 1'b0;
        br_target = 27'h0; imem_rdata = 32'h0;

        //                 r  ns dn fl bt           inst          pc           en ea
        main_tab[0]  = mk(1, 1, 1, 0, 27'h0,       32'h0,        27'h0,       0, 25'h0);
        main_tab[1]  = mk(0, 1, 1, 0, 27'h0,       32'h0,        27'h0,       1, 25'h0);
        main_tab[2]  = mk(0, 1, 1, 0, 27'h0,       32'h0,        27'h0,       1, 25'h1);
        main_tab[3]  = mk(0, 1, 1, 0, 27'h0,       32'h1,        27'h4,       1, 25'h2);
        main_tab[4]  = mk(0, 1, 1, 0, 27'h0,       32'h2,        27'h8,       1, 25'h3);
        main_tab[5]  = mk(0, 1, 1, 0, 27'h0,       32'h3,        27'hC,       1, 25'h4);
        main_tab[6]  = mk(0, 1, 1, 0, 27'h0,       32'h4,        27'h10,      1, 25'h5);
        // n_stall low for three cycles while inst 5 is presented
        main_tab[7]  = mk(0, 0, 1, 0, 27'h0,       32'h5,        27'h14,      0, 25'h5);
        main_tab[8]  = mk(0, 0, 1, 0, 27'h0,       32'h5,        27'h14,      0, 25'h5);
        main_tab[9]  = mk(0, 0, 1, 0, 27'h0,       32'h5,        27'h14,      0, 25'h5);
        main_tab[10] = mk(0, 1, 1, 0, 27'h0,       32'h5,        27'h14,      1, 25'h6);
        // decode stall while inst 6 is presented, then flush out of HOLD
        main_tab[11] = mk(0, 1, 0, 0, 27'h0,       32'h6,        27'h18,      0, 25'h6);
        main_tab[12] = mk(0, 1, 0, 0, 27'h0,       32'h6,        27'h18,      0, 25'h6);
        main_tab[13] = mk(0, 1, 0, 1, 27'h200,     32'h6,        27'h18,      1, 25'h80);
        main_tab[14] = mk(0, 1, 1, 0, 27'h0,       32'h80,       27'h200,     1, 25'h81);
        main_tab[15] = mk(0, 1, 1, 0, 27'h0,       32'h81,       27'h204,     1, 25'h82);
        // redirect near the top of the address space and wrap to 0
        main_tab[16] = mk(0, 1, 1, 1, 27'h7FFFFF8, 32'h82,       27'h208,     1, 25'h1FFFFFE);
        main_tab[17] = mk(0, 1, 1, 0, 27'h0,       32'h1FFFFFE,  27'h7FFFFF8, 1, 25'h1FFFFFF);
        main_tab[18] = mk(0, 1, 1, 0, 27'h0,       32'h1FFFFFE,  27'h7FFFFFC, 1, 25'h0);
        main_tab[19] = mk(0, 1, 1, 0, 27'h0,       32'h0,        27'h0,       1, 25'h1);
        // enter HOLD, then reset together with flush: reset wins
        main_tab[20] = mk(0, 0, 1, 0, 27'h0,       32'h1,        27'h4,       0, 25'h1);
        main_tab[21] = mk(1, 0, 1, 1, 27'h200,     32'h1,        27'h4,       0, 25'h1);
        main_tab[22] = mk(0, 0, 1, 0, 27'h0,       32'h0,        27'h0,       1, 25'h0);
        main_tab[23] = mk(0, 1, 1, 0, 27'h0,       32'h0,        27'h0,       1, 25'h1);

        // Jump word 0x1007 at byte 0x8 targets 0x100.
        jmp_tab[0]  = mk(1, 1, 1, 0, 27'h0, 32'h0,    27'h0,   0, 25'h0);
        jmp_tab[1]  = mk(0, 1, 1, 0, 27'h0, 32'h0,    27'h0,   1, 25'h0);
        jmp_tab[2]  = mk(0, 1, 1, 0, 27'h0, 32'h0,    27'h0,   1, 25'h1);
        jmp_tab[3]  = mk(0, 1, 1, 0, 27'h0, 32'h1,    27'h4,   1, 25'h2);
        jmp_tab[4]  = mk(0, 1, 1, 0, 27'h0, 32'h1007, 27'h8,   1, 25'h40);
        jmp_tab[5]  = mk(0, 1, 1, 0, 27'h0, 32'h40,   27'h100, 1, 25'h41);
        // same jump consumed out of HOLD after a decode stall
        jmp_tab[6]  = mk(1, 1, 1, 0, 27'h0, 32'h41,   27'h104, 0, 25'h41);
        jmp_tab[7]  = mk(0, 1, 1, 0, 27'h0, 32'h0,    27'h0,   1, 25'h0);
        jmp_tab[8]  = mk(0, 1, 1, 0, 27'h0, 32'h0,    27'h0,   1, 25'h1);
        jmp_tab[9]  = mk(0, 1, 1, 0, 27'h0, 32'h1,    27'h4,   1, 25'h2);
        jmp_tab[10] = mk(0, 1, 0, 0, 27'h0, 32'h1007, 27'h8,   0, 25'h2);
        jmp_tab[11] = mk(0, 1, 1, 0, 27'h0, 32'h1007, 27'h8,   1, 25'h40);
        jmp_tab[12] = mk(0, 1, 1, 0, 27'h0, 32'h40,   27'h100, 1, 25'h41);

        // Unchecked reset cycle so the DUT leaves its power-up state.
        @(posedge clk);
        #1;
        apply("init", -1, main_tab[0], 1'b0);

        for (int i = 0; i < 24; i++) apply("main", i, main_tab[i], 1'b1);

        jump_en = 1'b1;
        apply("jrst", -1, jmp_tab[0], 1'b0);
        for (int i = 0; i < 13; i++) apply("jump", i, jmp_tab[i], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, default 27'h0, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 n_stall  input  1  global pipeline enable; 0 = hold.
REQ-005 dec_nstall  input  1  decode hazard enable; 0 = decode cannot accept.
REQ-006 flush  input  1  branch-taken redirect from execute.
REQ-007 br_target  input  27  byte address of the taken-branch target; valid when flush=1.
REQ-008 imem_en  output  1  instruction-memory read request.
REQ-009 imem_addr  output  25  word address of the request (byte PC[26:2]).
REQ-010 imem_rdata  input  32  instruction word, valid only in the cycle after imem_en=1.
REQ-011 inst  output  32  instruction presented to decode.
REQ-012 if_pc  output  27  byte PC of inst.

Function
REQ-013 Define advance = n_stall & dec_nstall; inst is consumed at a rising edge where advance=1.
REQ-014 FSM states: BOOT (nothing presented), RUN (presented word is imem_rdata, PC in pc_q), HOLD (presented word is hold_inst, PC in hold_pc).
REQ-015 inst = 32'h0 in BOOT, imem_rdata in RUN, hold_inst in HOLD; if_pc = 0 in BOOT, pc_q in RUN, hold_pc in HOLD.
REQ-016 Redirect priority each cycle: flush > jump > sequential.
REQ-017 flush=1 (any state, regardless of advance): imem_en=1, imem_addr=br_target[26:2], pc_q<=br_target, next state RUN, hold contents discarded.
REQ-018 BOOT without flush: imem_en=1, imem_addr=RESET_PC[26:2], pc_q<=RESET_PC, next state RUN; n_stall is ignored.
REQ-019 Jump: in RUN/HOLD with advance=1 and inst[2:0]=3'b111, target = {inst[30:6],2'b00}; imem_en=1, imem_addr=target[26:2], pc_q<=target, next state RUN; no bubble.
REQ-020 Sequential: in RUN/HOLD with advance=1 and no jump: imem_en=1, imem_addr=(pc_q+4)[26:2], pc_q<=pc_q+4, next state RUN.
REQ-021 PC arithmetic is modulo 2^27; pc_q+4 from 27'h7FFFFFC wraps to 0.
REQ-022 RUN with advance=0 and no flush: imem_en=0; hold_inst<=imem_rdata, hold_pc<=pc_q; next state HOLD.
REQ-023 HOLD with advance=0 and no flush: imem_en=0; hold registers and pc_q are unchanged; state stays HOLD.
REQ-024 In HOLD, pc_q equals hold_pc, so the sequential successor is hold_pc+4.
REQ-025 imem_addr and imem_en are combinational from state, inputs and imem_rdata/hold_inst; imem_addr = pc_q[26:2] when imem_en=0.
REQ-026 Fetch-to-decode latency: an instruction is presented in the cycle after its request.
REQ-027 No instruction is lost or duplicated across any stall length.

Reset
REQ-028 rst=1 at any edge, including mid-stall and in HOLD: state<=BOOT, pc_q<=RESET_PC, hold_inst<=0, hold_pc<=0; rst overrides flush.
REQ-029 During and after reset until the first RUN cycle: inst=32'h0, if_pc=0, imem_en=0 while rst=1.

Structure
REQ-030 Shared package core_pkg holds RESET_PC default, OP_JUMP=3'b111, NOP_INST=32'h0, and enum fetch_state_t {BOOT, RUN, HOLD}.
REQ-031 Single flat module; no sub-module; the instruction memory is external.

Verification
REQ-032 Reset, then a free run with memory word[i]=i (no op 111) -> cycle 1 imem_addr=0; cycle 2 onward inst=0,1,2,… with if_pc=0,4,8,….
REQ-033 n_stall=0 for 3 cycles while inst=5 (if_pc=0x14) -> inst/if_pc stay 5/0x14 and imem_en=0 throughout; after release the next inst=6 at if_pc 0x18.
REQ-034 Word at 0x8 = jump with inst[30:6]=0x40 -> the cycle after it is consumed, if_pc=0x100 with no bubble.
REQ-035 flush=1 with br_target=0x200 during HOLD -> next cycle if_pc=0x200; the held word is never presented again.
REQ-036 Sequential run reaching pc_q=0x7FFFFFC -> the next request has imem_addr=0 and if_pc=0.
REQ-037 rst asserted in HOLD together with flush=1 -> BOOT; next fetch from RESET_PC, not br_target.
